// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and round-robin helper for the memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   // Largest requester count the helper function supports
   localparam int unsigned MAX_REQ   = 8;
   localparam int unsigned MAX_IDX_W = 3;

   typedef enum logic [0:0] {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                 found;
      logic [MAX_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of valid[num-1:0], searching upward from ptr with wrap.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                        input logic [MAX_IDX_W-1:0] ptr,
                                        input int unsigned          num);
      rr_pick_t    res;
      int unsigned pos;
      res = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         pos = (32'(ptr) + k) % num;
         if (k < num && !res.found && valid[MAX_IDX_W'(pos)]) begin
            res.found = 1'b1;
            res.idx   = MAX_IDX_W'(pos);
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_picker
//  Description : Combinational round-robin picker: rotate the request vector
//                so ptr sits at bit 0, priority-encode, then un-rotate.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [NUM_REQ-1:0]   w_rot;
   rr_pick_t             w_pick;
   logic [MAX_IDX_W:0]   w_sum;
   logic [MAX_IDX_W:0]   w_unrot;

   // Doubling the vector turns the rotate into a plain right shift
   assign w_dbl = {valid_i, valid_i};
   assign w_rot = NUM_REQ'(w_dbl >> ptr_i);

   // Priority-encode the rotated vector from bit 0
   assign w_pick  = rr_pick(MAX_REQ'(w_rot), MAX_IDX_W'(0), NUM_REQ);
   assign found_o = w_pick.found;

   // Un-rotate: add the pointer back, modulo NUM_REQ
   assign w_sum   = {1'b0, w_pick.idx} + (MAX_IDX_W+1)'(ptr_i);
   assign w_unrot = (w_sum >= (MAX_IDX_W+1)'(NUM_REQ)) ?
                    (w_sum - (MAX_IDX_W+1)'(NUM_REQ)) : w_sum;
   assign idx_o   = IDX_W'(w_unrot);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter in front of the single-port data memory,
//                with bounded locked bursts, range checking and a registered
//                one-cycle response per transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned ADDR_LIMIT    = 32768,
   parameter int unsigned MAX_HOLD      = 8
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_REQ-1:0]                     req_valid_i,
   output logic [NUM_REQ-1:0]                     req_ready_o,
   input  logic [NUM_REQ-1:0]                     req_we_i,
   input  logic [NUM_REQ-1:0]                     req_be_i,
   input  logic [NUM_REQ-1:0]                     req_lock_i,
   input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]  req_addr_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_wdata_i,
   output logic [NUM_REQ-1:0]                     rsp_valid_o,
   output logic [DATA_WIDTH-1:0]                  rsp_data_o,
   output logic                                   rsp_err_o,
   output logic [ADDRESS_WIDTH-1:0]               mem_address_o,
   output logic [DATA_WIDTH-1:0]                  mem_write_data_o,
   output logic                                   mem_we_o,
   output logic                                   mem_re_o,
   output logic                                   mem_be_o,
   input  logic [DATA_WIDTH-1:0]                  mem_read_data_i
);

   localparam int unsigned                IDX_W      = $clog2(NUM_REQ);
   localparam int unsigned                HOLD_W     = $clog2(MAX_HOLD + 1);
   localparam logic [IDX_W-1:0]           LAST_IDX   = IDX_W'(NUM_REQ - 1);
   localparam logic [HOLD_W-1:0]          HOLD_LIMIT = HOLD_W'(MAX_HOLD);
   localparam logic [ADDRESS_WIDTH-1:0]   ADDR_END   = ADDRESS_WIDTH'(ADDR_LIMIT);

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
   endfunction

   arb_state_t              state_q, state_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
   logic                    idle_q, idle_d;
   logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic                    rsp_err_q, rsp_err_d;

   logic                    w_pick_found;
   logic [IDX_W-1:0]        w_pick_idx;
   logic [IDX_W-1:0]        w_winner;
   logic                    w_grant;
   logic                    w_xfer;
   logic                    w_in_range;
   logic                    w_strobe;
   logic [NUM_REQ-1:0]      w_onehot;
   logic [HOLD_W-1:0]       w_hold_next;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .valid_i (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .found_o (w_pick_found),
      .idx_o   (w_pick_idx)
   );

   // While locked only the owner may win; no grant at all during reset
   assign w_winner    = (state_q == LOCKED) ? owner_q : w_pick_idx;
   assign w_grant     = (state_q == LOCKED) ? req_valid_i[owner_q] : w_pick_found;
   assign w_xfer      = w_grant & ~reset;
   assign w_onehot    = NUM_REQ'(1) << w_winner;
   assign req_ready_o = w_xfer ? w_onehot : '0;

   // Out-of-range beats are accepted but never reach the memory
   assign w_in_range       = req_addr_i[w_winner] < ADDR_END;
   assign w_strobe         = w_xfer & w_in_range;
   assign mem_re_o         = w_strobe & ~req_we_i[w_winner];
   assign mem_we_o         = w_strobe &  req_we_i[w_winner];
   assign mem_be_o         = w_strobe &  req_be_i[w_winner];
   assign mem_address_o    = w_strobe ? req_addr_i[w_winner]  : '0;
   assign mem_write_data_o = w_strobe ? req_wdata_i[w_winner] : '0;

   assign w_hold_next = hold_cnt_q + HOLD_W'(1);

   // Next-state for the lock FSM, round-robin pointer and hold/idle tracking
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      hold_cnt_d = hold_cnt_q;
      idle_d     = idle_q;
      case (state_q)
         ARB: begin
            if (w_xfer) begin
               rr_ptr_d = next_idx(w_winner);
               if (req_lock_i[w_winner]) begin
                  state_d    = LOCKED;
                  owner_d    = w_winner;
                  hold_cnt_d = HOLD_W'(1);
                  idle_d     = 1'b0;
               end
            end
         end
         LOCKED: begin
            if (w_xfer) begin
               hold_cnt_d = w_hold_next;
               idle_d     = 1'b0;
               // The beat that hits the hold limit is still performed
               if (!req_lock_i[owner_q] || w_hold_next == HOLD_LIMIT) begin
                  state_d    = ARB;
                  rr_ptr_d   = next_idx(owner_q);
                  hold_cnt_d = '0;
               end
            end else if (idle_q) begin
               // Second idle cycle in a row: the owner abandoned the lock
               state_d    = ARB;
               rr_ptr_d   = next_idx(owner_q);
               hold_cnt_d = '0;
               idle_d     = 1'b0;
            end else begin
               idle_d = 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // Response for the beat transferred this cycle, presented next cycle
   always_comb begin
      rsp_valid_d = '0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = rsp_data_q;
      if (w_xfer) begin
         rsp_valid_d = w_onehot;
         rsp_err_d   = ~w_in_range;
         rsp_data_d  = (w_in_range && !req_we_i[w_winner]) ? mem_read_data_i : '0;
      end
   end

   // State and response registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ARB;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         hold_cnt_q  <= '0;
         idle_q      <= 1'b0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         hold_cnt_q  <= hold_cnt_d;
         idle_q      <= idle_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a small word memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [3:0]        req_valid = '0;
   logic [3:0]        req_ready;
   logic [3:0]        req_we = '0;
   logic [3:0]        req_be = '0;
   logic [3:0]        req_lock = '0;
   logic [3:0][31:0]  req_addr = '0;
   logic [3:0][31:0]  req_wdata = '0;
   logic [3:0]        rsp_valid;
   logic [31:0]       rsp_data;
   logic              rsp_err;
   logic [31:0]       mem_address;
   logic [31:0]       mem_write_data;
   logic              mem_we, mem_re, mem_be;
   logic [31:0]       mem_read_data;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:63];

   mem_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_we_i         (req_we),
      .req_be_i         (req_be),
      .req_lock_i       (req_lock),
      .req_addr_i       (req_addr),
      .req_wdata_i      (req_wdata),
      .rsp_valid_o      (rsp_valid),
      .rsp_data_o       (rsp_data),
      .rsp_err_o        (rsp_err),
      .mem_address_o    (mem_address),
      .mem_write_data_o (mem_write_data),
      .mem_we_o         (mem_we),
      .mem_re_o         (mem_re),
      .mem_be_o         (mem_be),
      .mem_read_data_i  (mem_read_data)
   );

   always #5 clk = ~clk;

   // Memory model: preloaded while reset is high, byte or word writes
   assign mem_read_data = mem[mem_address[7:2]];
   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 64; k++)
            mem[k] <= (k == 4) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(k));
      end else if (mem_we) begin
         if (mem_be)
            mem[mem_address[7:2]][{mem_address[1:0], 3'b000} +: 8] <= mem_write_data[7:0];
         else
            mem[mem_address[7:2]] <= mem_write_data;
      end
   end

   typedef struct {
      logic [3:0]  valid, we, be, lock;
      logic [31:0] addr, wdata;
      logic [3:0]  e_ready;
      logic        e_re, e_we, e_be;
      logic [31:0] e_addr;
      logic [3:0]  e_rsp;
      logic        e_err;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(input logic [3:0] valid, we, be, lock,
                               input logic [31:0] addr, wdata,
                               input logic [3:0] e_ready,
                               input logic e_re, e_we, e_be,
                               input logic [31:0] e_addr,
                               input logic [3:0] e_rsp,
                               input logic e_err,
                               input logic [31:0] e_data);
      vec_t v;
      v.valid = valid; v.we = we; v.be = be; v.lock = lock;
      v.addr = addr; v.wdata = wdata;
      v.e_ready = e_ready; v.e_re = e_re; v.e_we = e_we; v.e_be = e_be;
      v.e_addr = e_addr; v.e_rsp = e_rsp; v.e_err = e_err; v.e_data = e_data;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Requester i uses address base + 4*i; all share the write data
   task automatic drive(input logic [3:0] valid, we, be, lock,
                        input logic [31:0] addr, wdata);
      req_valid = valid; req_we = we; req_be = be; req_lock = lock;
      for (int i = 0; i < 4; i++) begin
         req_addr[i]  = addr + 32'(4 * i);
         req_wdata[i] = wdata;
      end
   endtask

   task automatic apply(input vec_t v, input int n);
      @(negedge clk);
      drive(v.valid, v.we, v.be, v.lock, v.addr, v.wdata);
      #1;
      chk($sformatf("v%0d ready", n),    32'(req_ready),  32'(v.e_ready));
      chk($sformatf("v%0d mem_re", n),   32'(mem_re),     32'(v.e_re));
      chk($sformatf("v%0d mem_we", n),   32'(mem_we),     32'(v.e_we));
      chk($sformatf("v%0d mem_be", n),   32'(mem_be),     32'(v.e_be));
      chk($sformatf("v%0d mem_addr", n), mem_address,     v.e_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rsp_valid", n), 32'(rsp_valid), 32'(v.e_rsp));
      if (v.e_rsp != 4'b0000)
         chk($sformatf("v%0d rsp_err", n), 32'(rsp_err), 32'(v.e_err));
      chk($sformatf("v%0d rsp_data", n), rsp_data, v.e_data);
   endtask

   initial begin
      //            valid    we       be       lock     addr          wdata     ready   re    we    be    eaddr         rsp     err   data
      vecs[0]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h10,       32'h0,    4'b0001, 1'b1, 1'b0, 1'b0, 32'h10,   4'b0001, 1'b0, 32'hDEADBEEF);
      vecs[1]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h10,       32'h0,    4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0000, 1'b0, 32'hDEADBEEF);
      vecs[2]  = mk(4'b1000, 4'b0000, 4'b0000, 4'b0000, 32'h10,       32'h0,    4'b1000, 1'b1, 1'b0, 1'b0, 32'h1C,   4'b1000, 1'b0, 32'h10000007);
      vecs[3]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h10,       32'h0,    4'b0001, 1'b1, 1'b0, 1'b0, 32'h10,   4'b0001, 1'b0, 32'hDEADBEEF);
      vecs[4]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h10,       32'h0,    4'b0010, 1'b1, 1'b0, 1'b0, 32'h14,   4'b0010, 1'b0, 32'h10000005);
      vecs[5]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h10,       32'h0,    4'b0100, 1'b1, 1'b0, 1'b0, 32'h18,   4'b0100, 1'b0, 32'h10000006);
      vecs[6]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h10,       32'h0,    4'b1000, 1'b1, 1'b0, 1'b0, 32'h1C,   4'b1000, 1'b0, 32'h10000007);
      vecs[7]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h10,       32'h0,    4'b0001, 1'b1, 1'b0, 1'b0, 32'h10,   4'b0001, 1'b0, 32'hDEADBEEF);
      vecs[8]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h10,       32'h0,    4'b0010, 1'b1, 1'b0, 1'b0, 32'h14,   4'b0010, 1'b0, 32'h10000005);
      vecs[9]  = mk(4'b0100, 4'b0100, 4'b0100, 4'b0000, 32'h19,       32'hAB,   4'b0100, 1'b0, 1'b1, 1'b1, 32'h21,   4'b0100, 1'b0, 32'h0);
      vecs[10] = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 32'h18,       32'h0,    4'b0100, 1'b1, 1'b0, 1'b0, 32'h20,   4'b0100, 1'b0, 32'h1000AB08);
      vecs[11] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h8000,     32'h0,    4'b0001, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0001, 1'b1, 32'h0);
      vecs[12] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h7FFC,     32'h0,    4'b0001, 1'b1, 1'b0, 1'b0, 32'h7FFC, 4'b0001, 1'b0, 32'h1000003F);
      vecs[13] = mk(4'b0010, 4'b0010, 4'b0000, 4'b0000, 32'h7FFC,     32'h55,   4'b0010, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0010, 1'b1, 32'h0);

      // Reset state, with every requester asking while reset is held
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h10, 32'h0);
      #1;
      chk("rst ready",     32'(req_ready),  32'h0);
      chk("rst mem_re",    32'(mem_re),     32'h0);
      chk("rst rsp_valid", 32'(rsp_valid),  32'h0);
      chk("rst rsp_data",  rsp_data,        32'h0);
      chk("rst rsp_err",   32'(rsp_err),    32'h0);
      chk("rst state",     32'(dut.state_q), 32'(ARB));
      chk("rst rr_ptr",    32'(dut.rr_ptr_q), 32'h0);
      chk("rst hold_cnt",  32'(dut.hold_cnt_q), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);

      for (int n = 0; n < 14; n++)
         apply(vecs[n], n);

      // Lock limit: pointer prepared to 1, then req1 locks against req3
      @(negedge clk);
      drive(4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h10, 32'h0);
      @(posedge clk);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         drive(4'b1010, 4'b0000, 4'b0000, 4'b0010, 32'h10, 32'h0);
         #1;
         chk($sformatf("lock ready c%0d", c), 32'(req_ready), (c == 8) ? 32'h8 : 32'h2);
         @(posedge clk);
         #1;
         chk($sformatf("lock rsp c%0d", c), 32'(rsp_valid), (c == 8) ? 32'h8 : 32'h2);
         chk($sformatf("lock data c%0d", c), rsp_data, (c == 8) ? 32'h10000007 : 32'h10000005);
      end

      // Abandoned lock: req1 owns the lock again but goes quiet for two cycles
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive(4'b1000, 4'b0000, 4'b0000, 4'b0000, 32'h10, 32'h0);
         #1;
         chk($sformatf("abandon ready c%0d", c), 32'(req_ready), (c == 2) ? 32'h8 : 32'h0);
         @(posedge clk);
      end

      // Reset in the middle of a locked burst from req0
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive(4'b0001, 4'b0000, 4'b0000, 4'b0001, 32'h10, 32'h0);
         #1;
         chk($sformatf("burst ready c%0d", c), 32'(req_ready), 32'h1);
         @(posedge clk);
      end
      #1;
      chk("burst state", 32'(dut.state_q), 32'(LOCKED));
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst ready",     32'(req_ready), 32'h0);
      chk("midrst mem_re",    32'(mem_re),    32'h0);
      chk("midrst rsp_valid", 32'(rsp_valid), 32'h0);
      @(posedge clk);
      #1;
      chk("midrst rsp_valid2", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);
      #1;
      chk("post state",    32'(dut.state_q),    32'(ARB));
      chk("post rr_ptr",   32'(dut.rr_ptr_q),   32'h0);
      chk("post hold_cnt", 32'(dut.hold_cnt_q), 32'h0);
      @(posedge clk);
      #1;
      chk("post rsp_valid", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      drive(4'b0100, 4'b0000, 4'b0000, 4'b0000, 32'h20, 32'h0);
      #1;
      chk("post ready", 32'(req_ready), 32'h4);
      @(posedge clk);
      #1;
      chk("post rsp", 32'(rsp_valid), 32'h4);
      chk("post data", rsp_data, 32'h1000000A);
      @(negedge clk);
      drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-port data memory among up to NUM_REQ requesters, such as the systolic-array operand loader, the result writeback unit and the host/debug port. It sits directly in front of the memory and drives its address, write_data, we, re and be inputs. It returns registered read data and a per-requester one-cycle response pulse. It supports short locked bursts with a bounded hold, and it rejects out-of-range addresses without touching memory.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_WIDTH, 32: data bus width
- ADDRESS_WIDTH, 32: byte-address width
- ADDR_LIMIT, 32768: first illegal byte address (MEM_SIZE*4)
- MAX_HOLD, 8: maximum consecutive beats a locking requester may keep the grant
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_be  in  NUM_REQ  1 = byte access, 0 = word access
- req_lock  in  NUM_REQ  keep grant for the next beat (burst)
- req_addr  in  NUM_REQ x ADDRESS_WIDTH  byte address
- req_wdata  in  NUM_REQ x DATA_WIDTH  write data
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owner
- rsp_data  out  DATA_WIDTH  registered read data (0 for writes and errors)
- rsp_err  out  1  qualifies rsp_valid: address out of range
- mem_address  out  ADDRESS_WIDTH  to memory
- mem_write_data  out  DATA_WIDTH  to memory
- mem_we, mem_re, mem_be  out  1 each  to memory
- mem_read_data  in  DATA_WIDTH  combinational read data from memory

## Operation
- Transfer: a beat transfers in any cycle where req_valid[i] and req_ready[i] are both high. Requests must hold valid, address, data and controls stable until accepted.
- Grant, state ARB:
  - Pick the first requester with valid set, searching from rr_ptr upward with wrap-around.
  - req_ready is high only for the winner.
  - After a transfer, rr_ptr becomes the winner index + 1, modulo NUM_REQ.
- Entering LOCKED: a transfer with req_lock high moves the FSM to LOCKED with owner = winner and hold_cnt = 1.
- Grant, state LOCKED:
  - The owner wins whenever its valid is high. Others see ready low.
  - If the owner's valid is low, the cycle is idle and no other requester is granted.
  - Each owner transfer increments hold_cnt.
- Leaving LOCKED, back to ARB with rr_ptr = owner + 1, on any of:
  - An owner transfer with req_lock low.
  - An owner transfer that makes hold_cnt reach MAX_HOLD. That beat is still performed.
  - Owner valid low for 2 consecutive cycles (abandoned lock).
- Memory drive:
  - For the winner with an in-range address (req_addr < ADDR_LIMIT), mem_re = !req_we, mem_we = req_we, mem_be = req_be, and address and data are passed through combinationally.
  - With no transfer, mem_re, mem_we and mem_be are 0, and mem_address and mem_write_data are 0.
- Out-of-range request: accepted normally, but no memory strobe is driven. The response carries rsp_err = 1 and rsp_data = 0.
- Response: every transfer produces rsp_valid[winner] on the next cycle.
  - rsp_data captures mem_read_data for in-range reads, and 0 otherwise.
  - rsp_data holds its value until the next response.

## Timing
- Reset values: rr_ptr 0, state ARB, hold_cnt 0, rsp_valid 0, rsp_data 0, rsp_err 0. All memory outputs are 0 and req_ready is 0 while reset is asserted.
- Accept is zero-latency: combinational from req_valid to req_ready. There is no combinational path from req_ready to req_valid.
- Read latency: request accepted in cycle N, rsp_valid and rsp_data in cycle N+1.
- Throughput: one beat per cycle, including back-to-back beats from different requesters.
- Simultaneous events: the transfer and the state/pointer update occur on the same edge. A lock release and a new arbitration take effect in the next cycle.
- Reset mid-burst: the FSM returns to ARB, pending responses are dropped, and no memory strobe is issued while reset is asserted.

## Structure
- Package mem_arb_pkg:
  - arb_state_t enum {ARB, LOCKED}
  - Index width: $clog2(NUM_REQ)
  - A helper function rr_pick(valid, ptr) returning the index and a found flag.
- Sub-module rr_priority_picker (combinational rotate, priority-encode, un-rotate). It is used by ARB.
- The FSM, counters, the memory mux and the response register live in mem_arbiter.

## Test plan
- Single reader: req 0 reads word address 0x10, with memory preloaded at 0x10 = 0xDEADBEEF. Expect req_ready[0] the same cycle, then rsp_valid[0] with rsp_data = 0xDEADBEEF in the next cycle.
- Fairness: all 4 requesters hold valid continuously, no lock. Grants must follow the order 0,1,2,3,0,1,… with exactly one req_ready per cycle.
- Byte write then read: req 2 writes be = 1 at address 0x21 with data 0xAB, then reads the word at 0x20. Bits [15:8] must be 0xAB, and rsp_valid[2] must pulse after each beat.
- Lock limit: req 1 asserts lock and valid for 12 beats while req 3 is also valid. Req 1 must receive exactly 8 beats, then req 3 is granted in the 9th cycle.
- Out of range: req 0 reads at address 0x8000. Expect no mem_re or mem_we pulse, rsp_valid[0] = 1, rsp_err = 1 and rsp_data = 0.
- Reset mid-burst: assert reset during LOCKED after 3 beats. After release, the state is ARB, rr_ptr = 0, and no rsp_valid is produced for the dropped beat.
